wb4_bus_arbiter: RTL and testbench

//  Two-master to one-slave Wishbone B4 (pipelined) arbiter. Sits directly downstream of the core.
//  It merges the core's instruction bus (inst_bus) and data bus (data_bus) onto a single memory port.

---
 rtl/wb4_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_wb4_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb4_bus_arbiter.sv
// Purpose: two-master (instruction, data) to one-slave Wishbone B4 pipelined arbiter with watchdog.
// Latency: 1 cycle request-to-grant; datapath is combinational from the registered grant.
// Backpressure: slave m_stall is passed to the owner only; a non-owner and both masters in IDLE see stall=1.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-low reset
//   i_* / d_*       instruction / data master: cyc, stb, we, adr, dat_w, sel in; dat_r, ack, err, stall out
//   m_*             slave port: cyc, stb, we, adr, dat_w, sel out; dat_r, ack, err, stall in
module wb4_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DATA_PRIO   = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_cyc,
    input  logic                i_stb,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_adr,
    input  logic [DATA_W-1:0]   i_dat_w,
    input  logic [DATA_W/8-1:0] i_sel,
    output logic [DATA_W-1:0]   i_dat_r,
    output logic                i_ack,
    output logic                i_err,
    output logic                i_stall,

    input  logic                d_cyc,
    input  logic                d_stb,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_adr,
    input  logic [DATA_W-1:0]   d_dat_w,
    input  logic [DATA_W/8-1:0] d_sel,
    output logic [DATA_W-1:0]   d_dat_r,
    output logic                d_ack,
    output logic                d_err,
    output logic                d_stall,

    output logic                m_cyc,
    output logic                m_stb,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_adr,
    output logic [DATA_W-1:0]   m_dat_w,
    output logic [DATA_W/8-1:0] m_sel,
    input  logic [DATA_W-1:0]   m_dat_r,
    input  logic                m_ack,
    input  logic                m_err,
    input  logic                m_stall
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 2) < 4) ? 4 : $clog2(TIMEOUT_CYC + 2);
    // Watchdog fires on the cycle that would be the TIMEOUT_CYC-th waiting cycle.
    localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_d;      // last grant went to the data master
    logic               last_d_nxt;
    logic [CNT_W-1:0]   outst;
    logic [CNT_W-1:0]   wdog;

    logic               own_i;
    logic               own_d;
    logic               sel_cyc;
    logic               sel_stb;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_adr;
    logic [DATA_W-1:0]  sel_dat_w;
    logic [SEL_W-1:0]   sel_sel;
    logic               resp;
    logic               accept;
    logic               wd_fire;

    assign own_i = (state == GNT_I);
    assign own_d = (state == GNT_D);
    assign resp  = m_ack | m_err;

    // Owner mux; everything reads zero while nobody owns the bus.
    always_comb begin
        sel_cyc   = 1'b0;
        sel_stb   = 1'b0;
        sel_we    = 1'b0;
        sel_adr   = '0;
        sel_dat_w = '0;
        sel_sel   = '0;
        if (own_i) begin
            sel_cyc   = i_cyc;
            sel_stb   = i_stb;
            sel_we    = i_we;
            sel_adr   = i_adr;
            sel_dat_w = i_dat_w;
            sel_sel   = i_sel;
        end else if (own_d) begin
            sel_cyc   = d_cyc;
            sel_stb   = d_stb;
            sel_we    = d_we;
            sel_adr   = d_adr;
            sel_dat_w = d_dat_w;
            sel_sel   = d_sel;
        end
    end

    assign wd_fire = (TIMEOUT_CYC != 0) && (own_i || own_d) && (outst != '0)
                     && !resp && (wdog == WD_LAST);

    // The forced drop on a watchdog fire kills the cycle in the same clock.
    assign m_cyc   = sel_cyc & ~wd_fire;
    assign m_stb   = sel_cyc & sel_stb & ~wd_fire;
    assign m_we    = sel_we;
    assign m_adr   = sel_adr;
    assign m_dat_w = sel_dat_w;
    assign m_sel   = sel_sel;

    assign i_dat_r = m_dat_r;
    assign d_dat_r = m_dat_r;
    assign i_ack   = own_i & m_ack;
    assign i_err   = own_i & (m_err | wd_fire);
    assign i_stall = ~own_i | m_stall;
    assign d_ack   = own_d & m_ack;
    assign d_err   = own_d & (m_err | wd_fire);
    assign d_stall = ~own_d | m_stall;

    assign accept  = m_stb & ~m_stall;

    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        case (state)
            IDLE: begin
                // With both requesting, round-robin hands the bus to whoever did not have it last.
                if (d_cyc && (!i_cyc || (DATA_PRIO != 0) || !last_d)) begin
                    state_nxt = GNT_D;
                end else if (i_cyc) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_I: begin
                if (!i_cyc || wd_fire) begin
                    state_nxt  = IDLE;
                    last_d_nxt = 1'b0;
                end
            end
            GNT_D: begin
                if (!d_cyc || wd_fire) begin
                    state_nxt  = IDLE;
                    last_d_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
        end
    end

    // Outstanding/watchdog are per grant: wiped whenever the bus is or becomes unowned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outst <= '0;
            wdog  <= '0;
        end else if (state == IDLE || state_nxt == IDLE) begin
            outst <= '0;
            wdog  <= '0;
        end else begin
            if (accept && !resp) begin
                outst <= outst + CNT_ONE;
            end else if (!accept && resp && (outst != '0)) begin
                outst <= outst - CNT_ONE;
            end
            if (resp) begin
                wdog <= '0;
            end else if (outst != '0) begin
                wdog <= wdog + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_wb4_bus_arbiter.sv
// Purpose: directed bench for wb4_bus_arbiter; two instances (priority+watchdog 8, round-robin+no watchdog).
// Latency: each instance checked every cycle against a cycle-level reference model of the arbitration rules.
// Backpressure: slave stall driven by the directed vectors; stall mirroring checked through the model.
module tb_wb4_bus_arbiter;

    logic        clk;
    logic        rst;

    logic        i_cyc, i_stb, i_we;
    logic [31:0] i_adr, i_dat_w;
    logic [3:0]  i_sel;
    logic        d_cyc, d_stb, d_we;
    logic [31:0] d_adr, d_dat_w;
    logic [3:0]  d_sel;
    logic [31:0] m_dat_r;
    logic        m_ack, m_err, m_stall;

    // p_*: DATA_PRIO=1, TIMEOUT_CYC=8.  r_*: DATA_PRIO=0, TIMEOUT_CYC=0.
    logic [31:0] p_i_dat_r, p_d_dat_r, p_m_adr, p_m_dat_w;
    logic        p_i_ack, p_i_err, p_i_stall, p_d_ack, p_d_err, p_d_stall;
    logic        p_m_cyc, p_m_stb, p_m_we;
    logic [3:0]  p_m_sel;
    logic [31:0] r_i_dat_r, r_d_dat_r, r_m_adr, r_m_dat_w;
    logic        r_i_ack, r_i_err, r_i_stall, r_d_ack, r_d_err, r_d_stall;
    logic        r_m_cyc, r_m_stb, r_m_we;
    logic [3:0]  r_m_sel;

    int n_checks = 0;
    int n_errors = 0;

    wb4_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1), .TIMEOUT_CYC(8)) u_dut_p (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel),
        .i_dat_r(p_i_dat_r), .i_ack(p_i_ack), .i_err(p_i_err), .i_stall(p_i_stall),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_w(d_dat_w), .d_sel(d_sel),
        .d_dat_r(p_d_dat_r), .d_ack(p_d_ack), .d_err(p_d_err), .d_stall(p_d_stall),
        .m_cyc(p_m_cyc), .m_stb(p_m_stb), .m_we(p_m_we), .m_adr(p_m_adr), .m_dat_w(p_m_dat_w),
        .m_sel(p_m_sel), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall)
    );

    wb4_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(0), .TIMEOUT_CYC(0)) u_dut_r (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel),
        .i_dat_r(r_i_dat_r), .i_ack(r_i_ack), .i_err(r_i_err), .i_stall(r_i_stall),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_w(d_dat_w), .d_sel(d_sel),
        .d_dat_r(r_d_dat_r), .d_ack(r_d_ack), .d_err(r_d_err), .d_stall(r_d_stall),
        .m_cyc(r_m_cyc), .m_stb(r_m_stb), .m_we(r_m_we), .m_adr(r_m_adr), .m_dat_w(r_m_dat_w),
        .m_sel(r_m_sel), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // owner: 0 none, 1 instruction, 2 data.  wd = waiting cycles seen so far.
    typedef struct packed {
        int owner;
        int last;
        int outst;
        int wd;
    } mst_t;

    localparam mst_t MST_RESET = '{owner: 0, last: 1, outst: 0, wd: 0};

    mst_t st_p = MST_RESET;
    mst_t st_r = MST_RESET;

    task automatic model_step(input mst_t s, input int prio, input int to,
                              output logic [140:0] ev, output mst_t ns);
        logic        xc, xs, xw, fire, mc, ms, resp, acc;
        logic [31:0] xa, xd;
        logic [3:0]  xl;
        logic        ia, ie, ist, da, de, dst;
        ns = s;
        xc = 1'b0; xs = 1'b0; xw = 1'b0; xa = '0; xd = '0; xl = '0;
        if (s.owner == 1) begin
            xc = i_cyc; xs = i_stb; xw = i_we; xa = i_adr; xd = i_dat_w; xl = i_sel;
        end else if (s.owner == 2) begin
            xc = d_cyc; xs = d_stb; xw = d_we; xa = d_adr; xd = d_dat_w; xl = d_sel;
        end
        resp = m_ack | m_err;
        // This cycle is a waiting one; it fires if it would be the to-th.
        fire = (to > 0) && (s.owner != 0) && (s.outst > 0) && !resp && (s.wd + 1 == to);
        mc  = xc && !fire;
        ms  = xc && xs && !fire;
        ia  = (s.owner == 1) && m_ack;
        ie  = (s.owner == 1) && (m_err || fire);
        ist = (s.owner != 1) || m_stall;
        da  = (s.owner == 2) && m_ack;
        de  = (s.owner == 2) && (m_err || fire);
        dst = (s.owner != 2) || m_stall;
        ev = {mc, ms, xw, xa, xd, xl, m_dat_r, ia, ie, ist, m_dat_r, da, de, dst};

        if (s.owner == 0) begin
            if (i_cyc && d_cyc)  ns.owner = (prio != 0 || s.last == 1) ? 2 : 1;
            else if (d_cyc)      ns.owner = 2;
            else if (i_cyc)      ns.owner = 1;
        end else if (!xc || fire) begin
            ns.last  = s.owner;
            ns.owner = 0;
            ns.outst = 0;
            ns.wd    = 0;
        end else begin
            acc = ms && !m_stall;
            if (acc && !resp)                  ns.outst = s.outst + 1;
            else if (!acc && resp && s.outst > 0) ns.outst = s.outst - 1;
            if (resp)               ns.wd = 0;
            else if (s.outst > 0)   ns.wd = s.wd + 1;
        end
    endtask

    // One compare process: every cycle, both instances, full output vector.
    always @(negedge clk) begin
        logic [140:0] ev, av;
        mst_t ns;
        if (!rst) begin
            st_p = MST_RESET;
            st_r = MST_RESET;
        end
        model_step(st_p, 1, 8, ev, ns);
        av = {p_m_cyc, p_m_stb, p_m_we, p_m_adr, p_m_dat_w, p_m_sel, p_i_dat_r,
              p_i_ack, p_i_err, p_i_stall, p_d_dat_r, p_d_ack, p_d_err, p_d_stall};
        n_checks++;
        if (av !== ev) begin
            n_errors++;
            $display("FAIL model_p t=%0t actual=%h required=%h", $time, av, ev);
        end
        if (rst) st_p = ns;
        model_step(st_r, 0, 0, ev, ns);
        av = {r_m_cyc, r_m_stb, r_m_we, r_m_adr, r_m_dat_w, r_m_sel, r_i_dat_r,
              r_i_ack, r_i_err, r_i_stall, r_d_dat_r, r_d_ack, r_d_err, r_d_stall};
        n_checks++;
        if (av !== ev) begin
            n_errors++;
            $display("FAIL model_r t=%0t actual=%h required=%h", $time, av, ev);
        end
        if (rst) st_r = ns;
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin alternation vectors (cycles 13..24) and the r-instance grant they imply.
    int          t3_i   [12] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    int          t3_d   [12] = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 1, 1, 0};
    int          t3_cyc [12] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    logic [31:0] t3_adr [12] = '{32'h0, 32'h2000, 32'h0, 32'h0, 32'h1000, 32'h0,
                                 32'h0, 32'h2000, 32'h0, 32'h0, 32'h1000, 32'h0};

    initial begin
        rst = 1'b0;
        i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat_w = '0; i_sel = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_dat_w = '0; d_sel = '0;
        m_dat_r = '0; m_ack = 0; m_err = 0; m_stall = 0;
        #2;
        chk("reset_m_cyc", 32'(p_m_cyc), 32'd0);
        chk("reset_i_stall", 32'(p_i_stall), 32'd1);
        chk("reset_d_stall", 32'(p_d_stall), 32'd1);
        chk("reset_r_d_stall", 32'(r_d_stall), 32'd1);

        // single instruction read
        step(); rst = 1'b1; i_cyc = 1; i_stb = 1; i_adr = 32'h0000_0100; i_sel = 4'hF; #1;
        chk("t1_c1_m_cyc", 32'(p_m_cyc), 32'd0);
        step(); #1;
        chk("t1_c2_m_cyc", 32'(p_m_cyc), 32'd1);
        chk("t1_c2_m_adr", p_m_adr, 32'h0000_0100);
        step(); i_stb = 0; m_ack = 1; m_dat_r = 32'h0000_0013; #1;
        chk("t1_i_ack", 32'(p_i_ack), 32'd1);
        chk("t1_i_dat_r", p_i_dat_r, 32'h0000_0013);
        chk("t1_d_stall", 32'(p_d_stall), 32'd1);
        step(); m_ack = 0; i_cyc = 0; #1;
        chk("t1_drop_m_cyc", 32'(p_m_cyc), 32'd0);

        // simultaneous request, data priority
        step();
        i_cyc = 1; i_stb = 1; i_adr = 32'h0000_0200;
        d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 32'h8000_0000; d_sel = 4'hF; d_dat_w = 32'hCAFE_F00D; #1;
        chk("t2_idle_m_cyc", 32'(p_m_cyc), 32'd0);
        step(); #1;
        chk("t2_m_adr", p_m_adr, 32'h8000_0000);
        chk("t2_m_we", 32'(p_m_we), 32'd1);
        chk("t2_m_dat_w", p_m_dat_w, 32'hCAFE_F00D);
        chk("t2_i_stall", 32'(p_i_stall), 32'd1);
        step(); d_stb = 0; m_ack = 1; #1;
        chk("t2_d_ack", 32'(p_d_ack), 32'd1);
        chk("t2_i_ack", 32'(p_i_ack), 32'd0);
        step(); m_ack = 0; d_cyc = 0; d_we = 0; #1;
        step(); #1;
        chk("t2_gap_m_cyc", 32'(p_m_cyc), 32'd0);
        step(); #1;
        chk("t2_gnt_i_m_cyc", 32'(p_m_cyc), 32'd1);
        chk("t2_gnt_i_m_adr", p_m_adr, 32'h0000_0200);
        step(); i_stb = 0; m_ack = 1; #1;
        chk("t2_gnt_i_ack", 32'(p_i_ack), 32'd1);
        step(); m_ack = 0; i_cyc = 0; #1;

        // round-robin alternation on the r instance
        i_adr = 32'h1000; d_adr = 32'h2000; i_stb = 0; d_stb = 0;
        for (int k = 0; k < 12; k++) begin
            step(); i_cyc = t3_i[k][0]; d_cyc = t3_d[k][0]; #1;
            chk($sformatf("t3_r_m_cyc_%0d", k), 32'(r_m_cyc), 32'(t3_cyc[k]));
            if (t3_cyc[k] != 0) chk($sformatf("t3_r_m_adr_%0d", k), r_m_adr, t3_adr[k]);
        end

        // slave stall under GNT_D, then a single counted transaction
        step(); i_cyc = 0; d_cyc = 1; d_stb = 1; d_adr = 32'h3000; m_stall = 1; #1;
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk($sformatf("t4_d_stall_%0d", k), 32'(p_d_stall), 32'd1);
            chk($sformatf("t4_m_stb_%0d", k), 32'(p_m_stb), 32'd1);
        end
        step(); m_stall = 0; #1;
        chk("t4_release_d_stall", 32'(p_d_stall), 32'd0);
        step(); d_stb = 0; m_ack = 1; #1;
        chk("t4_d_ack", 32'(p_d_ack), 32'd1);
        step(); m_ack = 0; #1;
        for (int k = 0; k < 9; k++) step();
        #1;
        chk("t4_no_timeout_err", 32'(p_d_err), 32'd0);
        chk("t4_still_owned", 32'(p_m_cyc), 32'd1);

        // watchdog: one accepted strobe, slave silent
        step(); d_stb = 1; d_adr = 32'h4000; #1;
        chk("t5_m_stb", 32'(p_m_stb), 32'd1);
        step(); d_stb = 0; #1;
        chk("t5_wait1_err", 32'(p_d_err), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step(); #1;
            chk($sformatf("t5_wait%0d_err", k + 2), 32'(p_d_err), 32'd0);
        end
        step(); #1;
        chk("t5_fire_d_err", 32'(p_d_err), 32'd1);
        chk("t5_fire_m_cyc", 32'(p_m_cyc), 32'd0);
        chk("t5_r_no_err", 32'(r_d_err), 32'd0);
        chk("t5_r_m_cyc", 32'(r_m_cyc), 32'd1);
        step(); d_cyc = 0; m_ack = 1; #1;
        chk("t5_late_d_ack", 32'(p_d_ack), 32'd0);
        chk("t5_late_i_ack", 32'(p_i_ack), 32'd0);
        chk("t5_idle_m_cyc", 32'(p_m_cyc), 32'd0);
        step(); m_ack = 0; #1;

        // asynchronous reset in the middle of a bus cycle
        step(); i_cyc = 1; i_stb = 1; i_adr = 32'h5000; #1;
        step(); #1;
        chk("t6_gnt_m_cyc", 32'(p_m_cyc), 32'd1);
        step(); i_stb = 0; #1;
        chk("t6_pre_rst_m_cyc", 32'(p_m_cyc), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_m_cyc", 32'(p_m_cyc), 32'd0);
        chk("t6_rst_i_stall", 32'(p_i_stall), 32'd1);
        chk("t6_rst_r_m_cyc", 32'(r_m_cyc), 32'd0);
        step(); rst = 1'b1; i_stb = 1; i_adr = 32'h6000; #1;
        chk("t6_idle_m_cyc", 32'(p_m_cyc), 32'd0);
        step(); #1;
        chk("t6_fresh_m_cyc", 32'(p_m_cyc), 32'd1);
        chk("t6_fresh_m_adr", p_m_adr, 32'h6000);
        step(); i_stb = 0; m_ack = 1; m_dat_r = 32'h77; #1;
        chk("t6_fresh_i_ack", 32'(p_i_ack), 32'd1);
        chk("t6_fresh_i_dat_r", p_i_dat_r, 32'h77);
        step(); m_ack = 0; i_cyc = 0; #1;
        step();
        step();
        #5;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit actual=%0t required=<100000", $time);
        $fatal(1);
    end

endmodule
